// File: rtl/cpuc_package.sv
// Shared parameters, reset defaults and state encoding for the CPUC constant bank.
package cpuc_package;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_CONST  = 4;
  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int CNT_W      = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam int CONST_RST [NUM_CONST] = '{1, 2, 3, 4};

  typedef enum logic [1:0] {
    CB_IDLE,
    CB_COLLECT,
    CB_COMMIT
  } t_cbank_state;
endpackage

// File: rtl/cpuc_byte_assembler.sv
// Lane counter plus byte buffer; gathers LSB-first bytes into one word.
module cpuc_byte_assembler
  import cpuc_package::*;
(
  input  logic                  Clk,
  input  logic                  RstN,
  input  logic                  clr,
  input  logic                  take,
  input  logic [7:0]            din,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] word
);
  logic [CNT_W-1:0]     cnt;
  logic [BYTES-1:0][7:0] lane_q;

  assign last = (cnt == CNT_W'(BYTES - 1));
  assign word = lane_q;

  // cnt wraps to 0 on the final byte so the next word starts at lane 0
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN)      cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (take)  cnt <= last ? '0 : cnt + 1'b1;
  end

  // Lanes are not cleared; every lane is rewritten before a commit reads them.
  always_ff @(posedge Clk) begin
    if (take) lane_q[cnt] <= din;
  end
endmodule

// File: rtl/cpuc_const_bank.sv
// Writable constant bank: byte-serial writes assembled and committed atomically.
module cpuc_const_bank
  import cpuc_package::*;
(
  input  logic                  Clk,
  input  logic                  RstN,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [1:0]            wr_sel,
  input  logic [7:0]            wr_byte,
  input  logic                  wr_abort,
  input  logic                  restore,
  output logic                  wr_done,
  output logic [DATA_WIDTH-1:0] const0,
  output logic [DATA_WIDTH-1:0] const1,
  output logic [DATA_WIDTH-1:0] const2,
  output logic [DATA_WIDTH-1:0] const3
);
  t_cbank_state          state;
  logic [1:0]            sel_q;
  logic [DATA_WIDTH-1:0] cbank_q [NUM_CONST];
  logic [DATA_WIDTH-1:0] word;
  logic                  acc, take, clr, last, commit;

  assign wr_ready = (state != CB_COMMIT);
  assign acc      = wr_valid && wr_ready;
  // a byte handshaken alongside abort or restore is dropped
  assign take     = acc && !wr_abort && !restore;
  assign commit   = (state == CB_COMMIT) && !restore;
  assign clr      = restore || wr_abort || (state == CB_COMMIT);

  cpuc_byte_assembler u_asm (
    .Clk  (Clk),
    .RstN (RstN),
    .clr  (clr),
    .take (take),
    .din  (wr_byte),
    .last (last),
    .word (word)
  );

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state   <= CB_IDLE;
      sel_q   <= '0;
      wr_done <= 1'b0;
    end else begin
      wr_done <= commit;
      if (restore) begin
        state <= CB_IDLE;
      end else begin
        case (state)
          CB_IDLE: if (take) begin
            sel_q <= wr_sel;
            state <= (BYTES == 1) ? CB_COMMIT : CB_COLLECT;
          end
          CB_COLLECT: begin
            if (wr_abort)          state <= CB_IDLE;
            else if (take && last) state <= CB_COMMIT;
          end
          CB_COMMIT: state <= CB_IDLE;
          default:   state <= CB_IDLE;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_CONST; i++) begin : g_const
    always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN)                          cbank_q[i] <= DATA_WIDTH'(CONST_RST[i]);
      else if (restore)                   cbank_q[i] <= DATA_WIDTH'(CONST_RST[i]);
      else if (commit && sel_q == 2'(i))  cbank_q[i] <= word;
    end
  end

  assign const0 = cbank_q[0];
  assign const1 = cbank_q[1];
  assign const2 = cbank_q[2];
  assign const3 = cbank_q[3];
endmodule
